// File: rtl/rf_write_arbiter.sv
// Sole writer of the register-file write port: clears all registers after reset,
// then arbitrates writeback (priority) against an aux writer with a starvation bound.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_aux_valid,
  output logic              o_aux_ready,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_data,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_init_done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_next;
  logic [3:0]          r_wait_cnt, w_wait_cnt_next;
  logic                r_rf_we, w_rf_we_next;
  logic [ADDR_W-1:0]   r_rf_addr, w_rf_addr_next;
  logic [DATA_W-1:0]   r_rf_wdata, w_rf_wdata_next;
  logic                r_init_done, w_init_done_next;
  logic                w_force;
  logic                w_wb_acc;
  logic                w_aux_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_rf_we     <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clr_cnt   <= w_clr_cnt_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_rf_we     <= w_rf_we_next;
      r_rf_addr   <= w_rf_addr_next;
      r_rf_wdata  <= w_rf_wdata_next;
      r_init_done <= w_init_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_clr_cnt_next   = r_clr_cnt;
    w_wait_cnt_next  = r_wait_cnt;
    w_rf_we_next     = 1'b0;
    w_rf_addr_next   = r_rf_addr;
    w_rf_wdata_next  = r_rf_wdata;
    w_init_done_next = r_init_done;
    w_force          = 1'b0;
    w_wb_acc         = 1'b0;
    w_aux_acc        = 1'b0;
    o_wb_ready       = 1'b0;
    o_aux_ready      = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_rf_we_next    = 1'b1;
        w_rf_addr_next  = r_clr_cnt;
        w_rf_wdata_next = '0;
        w_clr_cnt_next  = r_clr_cnt + ADDR_W'(1);
        w_wait_cnt_next = '0;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_next     = ST_RUN;
          w_init_done_next = 1'b1;
        end
      end

      ST_RUN: begin
        w_force     = (r_wait_cnt == LIMIT);
        o_wb_ready  = !w_force;
        o_aux_ready = w_force | !i_wb_valid;
        w_aux_acc   = i_aux_valid & o_aux_ready;
        w_wb_acc    = i_wb_valid & o_wb_ready & !w_aux_acc;

        // x0 writes complete the handshake but never reach the register file
        if (w_aux_acc) begin
          if (i_aux_addr != '0) begin
            w_rf_we_next    = 1'b1;
            w_rf_addr_next  = i_aux_addr;
            w_rf_wdata_next = i_aux_data;
          end
        end else if (w_wb_acc) begin
          if (i_wb_addr != '0) begin
            w_rf_we_next    = 1'b1;
            w_rf_addr_next  = i_wb_addr;
            w_rf_wdata_next = i_wb_data;
          end
        end

        if (w_aux_acc || !i_aux_valid)
          w_wait_cnt_next = '0;
        else if (r_wait_cnt != LIMIT)
          w_wait_cnt_next = r_wait_cnt + 4'd1;
      end

      default: w_state_next = ST_CLEAR;
    endcase
  end

  assign o_rf_we     = r_rf_we;
  assign o_rf_addr   = r_rf_addr;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: clear sequence, vector table,
// randomized traffic against a grant model, and asynchronous reset cases.
module tb_rf_write_arbiter;

  localparam int STARVE = 4;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        init_done;

  int errors = 0;
  int checks = 0;
  int streak = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(STARVE)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_valid (wb_valid),
    .o_wb_ready (wb_ready),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_aux_valid(aux_valid),
    .o_aux_ready(aux_ready),
    .i_aux_addr (aux_addr),
    .i_aux_data (aux_data),
    .o_rf_we    (rf_we),
    .o_rf_addr  (rf_addr),
    .o_rf_wdata (rf_wdata),
    .o_init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        auxv;
    logic [4:0]  auxa;
    logic [31:0] auxd;
    logic        e_wbr;
    logic        e_auxr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    wb_valid  = wv;
    wb_addr   = wa;
    wb_data   = wd;
    aux_valid = av;
    aux_addr  = aa;
    aux_data  = ad;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rf_we"},     rf_we,     0);
    chk({tag, "_rf_addr"},   rf_addr,   0);
    chk({tag, "_rf_wdata"},  rf_wdata,  0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_wb_ready"},  wb_ready,  0);
    chk({tag, "_aux_ready"}, aux_ready, 0);
  endtask

  // Walks the clear sequence from address 0 through 'upto'
  task automatic check_clear(input int upto);
    for (int k = 0; k <= upto; k++) begin
      @(posedge clk); #1;
      chk("clr_we",   rf_we,    1);
      chk("clr_addr", rf_addr,  32'(k));
      chk("clr_data", rf_wdata, 0);
      chk("clr_done", init_done, (k == 31) ? 32'd1 : 32'd0);
      if (k < 31) begin
        chk("clr_wb_ready",  wb_ready,  0);
        chk("clr_aux_ready", aux_ready, 0);
      end
    end
    $display("clear checked through address %0d", upto);
  endtask

  task automatic reset_pulse(input string tag);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_reset_values({tag, "_async"});
    @(posedge clk); #1;
    check_reset_values({tag, "_held"});
    rst = 1'b0;
    streak = 0;
  endtask

  // One cycle of traffic checked against the grant rules: writeback wins unless
  // aux has already waited STARVE cycles; x0 writes are accepted but not written.
  task automatic model_cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                             input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             output logic wb_took, output logic aux_took);
    logic starved, e_wbr, e_auxr, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    drive(wv, wa, wd, av, aa, ad);
    #1;
    starved  = (streak >= STARVE);
    e_wbr    = !starved;
    e_auxr   = starved || !wv;
    chk("m_wb_ready",  wb_ready,  e_wbr);
    chk("m_aux_ready", aux_ready, e_auxr);
    aux_took = av && e_auxr;
    wb_took  = !aux_took && wv && e_wbr;
    streak   = (av && !aux_took) ? ((streak + 1 > STARVE) ? STARVE : streak + 1) : 0;
    e_we   = 1'b0;
    e_addr = 0;
    e_data = 0;
    if (aux_took) begin
      e_we = (aa != 0); e_addr = aa; e_data = ad;
    end else if (wb_took) begin
      e_we = (wa != 0); e_addr = wa; e_data = wd;
    end
    @(posedge clk); #1;
    chk("m_rf_we", rf_we, e_we);
    if (e_we) begin
      chk("m_rf_addr",  rf_addr,  e_addr);
      chk("m_rf_wdata", rf_wdata, e_data);
    end
    $display("cycle wb(v=%0d a=%0d) aux(v=%0d a=%0d) -> grant wb=%0d aux=%0d we=%0d",
             wv, wa, av, aa, wb_took, aux_took, e_we);
  endtask

  initial begin
    logic wt, at;
    logic        wv, av;
    logic [4:0]  wa, aa;
    logic [31:0] wd, ad;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hA5A5, 1'b1, 1'b1, 1'b1, 5'd7,  32'hA5A5};
    vecs[3]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b1, 5'd3,  32'h11};
    vecs[4]  = '{1'b1, 5'd4,  32'h22,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b1, 5'd4,  32'h22};
    vecs[5]  = '{1'b1, 5'd6,  32'h33,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b1, 5'd6,  32'h33};
    vecs[6]  = '{1'b1, 5'd8,  32'h44,       1'b1, 5'd9, 32'h99,   1'b1, 1'b0, 1'b1, 5'd8,  32'h44};
    vecs[7]  = '{1'b1, 5'd10, 32'h55,       1'b1, 5'd9, 32'h99,   1'b0, 1'b1, 1'b1, 5'd9,  32'h99};
    vecs[8]  = '{1'b1, 5'd10, 32'h55,       1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 5'd10, 32'h55};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[10] = '{1'b1, 5'd0,  32'h7,        1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 5'd0,  32'h0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    check_clear(31);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].wbv, vecs[i].wba, vecs[i].wbd, vecs[i].auxv, vecs[i].auxa, vecs[i].auxd);
      #1;
      chk($sformatf("v%0d_wb_ready", i),  wb_ready,  vecs[i].e_wbr);
      chk($sformatf("v%0d_aux_ready", i), aux_ready, vecs[i].e_auxr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_rf_addr", i),  rf_addr,  vecs[i].e_addr);
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_data);
      end
      $display("vector %0d applied", i);
    end
    streak = 0;

    // Alternating single-source requests: one write per cycle from each in turn
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0)
        model_cycle(1, 5'(i + 1), 32'hB000_0000 + 32'(i), 0, 0, 0, wt, at);
      else
        model_cycle(0, 0, 0, 1, 5'(i + 1), 32'hC000_0000 + 32'(i), wt, at);
      chk("alt_granted", (i % 2 == 0) ? wt : at, 1);
    end

    // Random traffic; a requester keeps its request stable until accepted
    wv = 0; wa = 0; wd = 0; av = 0; aa = 0; ad = 0;
    wt = 1; at = 1;
    for (int i = 0; i < 300; i++) begin
      if (!wv || wt) begin
        wv = ($urandom_range(0, 99) < 70);
        wa = 5'($urandom_range(0, 31));
        wd = $urandom;
      end
      if (!av || at) begin
        av = ($urandom_range(0, 99) < 50);
        aa = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      model_cycle(wv, wa, wd, av, aa, ad, wt, at);
    end

    // Reset mid-run, then mid-clear at address 17, then a full clear
    reset_pulse("rst_run");
    check_clear(17);
    reset_pulse("rst_clr17");
    check_clear(31);
    model_cycle(1, 5'd12, 32'hCAFEF00D, 0, 0, 0, wt, at);
    model_cycle(0, 0, 0, 1, 5'd13, 32'h0BADF00D, wt, at);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
